// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared definitions for the 4-requester round-robin arbiter:
//               FSM state encoding, requester count, pointer reset value and
//               the single-bit 4-to-1 mux used on the data path.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ = 4;

    // Pointer starts at the last index so requester 0 wins the first arbitration.
    localparam logic [1:0] PTR_RST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // One bit of the shared 4-to-1 datapath multiplexer.
    function automatic logic mux4_bit(input logic [3:0] in_bits, input logic [1:0] s);
        return in_bits[s];
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_if
// Description : Request/grant/data bundle between the four requesters and the
//               arbiter.
//   req     [3:0]  request vector (requesters -> arbiter)
//   d0..d3  [W-1:0] requester data words
//   gnt     [3:0]  one-hot grant or zero
//   sel     [1:0]  mux selector (index of current/last grant)
//   busy           grant currently held
//   q       [W-1:0] registered selected data
//   q_valid        q captured during a BUSY cycle
//   Modports: master = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if #(
    parameter int W = 2
);
    logic [3:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] q;
    logic         q_valid;

    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, busy, q, q_valid
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, busy, q, q_valid
    );
endinterface : mux4_rr_arbiter_if
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin picker. Searches req cyclically
//               starting at ptr_i+1; the requester at ptr_i itself is
//               considered last.
//   req_i [3:0]  request vector
//   ptr_i [1:0]  index of the last granted requester
//   idx_o [1:0]  winning index (meaningful only when any_o is high)
//   any_o        at least one request pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  wire logic [3:0] req_i,
    input  wire logic [1:0] ptr_i,
    output logic      [1:0] idx_o,
    output logic            any_o
);

    logic [1:0] cand;

    // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1),
    // so the nearest pending requester is the one left in idx_o.
    always_comb begin
        idx_o = ptr_i;
        cand  = ptr_i;
        any_o = |req_i;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_i + k[1:0];
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter/sequencer for the shared 4-to-1 mux
//               datapath. Grants one requester at a time, drives the mux
//               selector and registers the selected word with a valid flag.
//               States: IDLE (no grant), BUSY (grant held), GAP (one-cycle
//               turnaround with gnt = 0).
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bus          mux4_rr_arbiter_if.slave (req, d0..d3 in; gnt, sel, busy,
//                q, q_valid out)
//   Parameters   W        data width per requester
//                MAX_HOLD max BUSY cycles per grant when timeout is enabled
//   Macro        MUX_ARB_TIMEOUT_EN enables the hold-time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 2,
    parameter int MAX_HOLD = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux4_rr_arbiter_if.slave   bus
);

    arb_state_t   state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] q_q, q_d;
    logic         q_valid_q;

    logic [1:0]   pick_idx;
    logic         pick_any;
    logic [W-1:0] mux_out;
    logic         timeout;
    logic         others_req;

    rr_pick4 u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // In BUSY gnt_q is one-hot of the holder, so this masks the holder out.
    assign others_req = |(bus.req & ~gnt_q);

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    // Count saturates at MAX_HOLD so a lone holder keeps its grant, and a
    // late-arriving competitor then preempts on the next BUSY cycle.
    always_comb begin
        cnt_inc = (cnt_q == CNT_W'(MAX_HOLD)) ? cnt_q : cnt_q + CNT_W'(1);
        timeout = (cnt_inc == CNT_W'(MAX_HOLD)) && others_req;
        cnt_d   = cnt_q;
        if (state_q == BUSY) begin
            cnt_d = cnt_inc;
        end
        if (state_d == BUSY && state_q != BUSY) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, grant, selector and pointer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            BUSY: begin
                // A release in the same cycle as a timeout is just a release.
                if (!bus.req[sel_q] || timeout) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP never lasts past one cycle.
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
        endcase
    end

    // Data select: one shared 4-to-1 mux per data bit, steered by sel_q.
    for (genvar b = 0; b < W; b++) begin : g_bit
        assign mux_out[b] = mux4_bit({bus.d3[b], bus.d2[b], bus.d1[b], bus.d0[b]}, sel_q);
    end

    assign q_d = (state_q == BUSY) ? mux_out : q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            q_q       <= q_d;
            q_valid_q <= (state_q == BUSY);
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = (state_q == BUSY);
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;

endmodule : mux4_rr_arbiter
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1 multiplexer datapath. Four requesters contend for one output channel. The block grants exactly one requester at a time, drives the 2-bit mux selector, and registers the selected data word with a valid flag. It sits between the requesting logic and the downstream consumer of the multiplexed channel.

## Interface
- `W`, default 2: data width per requester.
- `MAX_HOLD`, default 8: maximum BUSY cycles per grant. Legal range is 1 or more. Used only when `MUX_ARB_TIMEOUT_EN` is defined.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  4: request vector; `req[i]` is high while requester i wants the channel.
- `d0`, `d1`, `d2`, `d3`  input  W each: requester data words.
- `gnt`  output  4: one-hot grant, or all zero.
- `sel`  output  2: mux selector, equal to the index of the current or last grant.
- `busy`  output  1: high while in BUSY.
- `q`  output  W: registered data of the selected requester.
- `q_valid`  output  1: `q` was captured during a BUSY cycle.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held.
  - GAP: one-cycle turnaround, `gnt` = 0.
- `ptr[1:0]` holds the index of the last granted requester.
- Arbitration from IDLE or GAP:
  - Search cyclically from `ptr+1` and pick the first i with `req[i]` = 1.
  - Next state is BUSY with `gnt` = one-hot(i), `sel` = i, `ptr` = i.
  - If no request is pending, next state is IDLE.
  - The previous holder has the lowest priority. It is re-granted if it is the only requester.
- GAP always arbitrates and never lingers. GAP lasts exactly one cycle.
- BUSY:
  - `req[sel]` sampled low moves the block to GAP.
  - Otherwise it stays in BUSY.
- Data path:
  - `q` <= the d word indexed by `sel` on every edge where the state is BUSY.
  - `q_valid` <= (state == BUSY).
  - Outside BUSY, `q` holds its last value.
- `sel` holds its last value in IDLE and GAP.
- `busy` = (state == BUSY).
- Simultaneous release and timeout in the same cycle is treated as a release; the next state is GAP.

## Timing
- Reset values:
  - State is IDLE.
  - `ptr` = 3, so requester 0 wins the first arbitration.
  - `gnt` = 0, `sel` = 0, `busy` = 0, `q` = 0, `q_valid` = 0.
- `rst` forces all of the above immediately, without waiting for a clock edge, including in the middle of BUSY.
- `req` to `gnt`: 1 cycle. A request sampled at edge n gives `gnt` valid after edge n.
- `gnt` to `q_valid`: 1 cycle. `q` lags `sel` by one edge.
- Release: `req[sel]` sampled low at edge n puts the block in GAP after edge n (`gnt` = 0). The next grant appears after edge n+1.
- Minimum spacing between two grants: 1 GAP cycle.
- All outputs are registered; there is no combinational path from `req` or `d*` to any output.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A hold counter of width clog2(MAX_HOLD+1) clears on entry to BUSY and increments on each BUSY cycle.
  - When the count reaches `MAX_HOLD` and any other `req` bit is high, the block moves to GAP even if `req[sel]` is still high.
  - If no other request is pending, the counter saturates and the grant is kept.
- `MUX_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - A grant is held for as long as `req[sel]` stays high.

## Structure
- Shared package `mux_arb_pkg`:
  - State encodings IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2.
  - Requester count constant N_REQ = 4.
  - Reset pointer constant PTR_RST = 2'd3.
- One sub-module, `rr_pick4`: combinational. Inputs are `req[3:0]` and `ptr[1:0]`. Outputs are the winning `idx[1:0]` and `any`.
- The top level holds the FSM, the pointer, the optional counter, and the output and data registers. The data select reuses the existing 4-to-1 mux for each bit of W.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 at once. Release `rst` and hold `req` = 4'b0000 → state stays IDLE and `gnt` stays 0.
- Single requester: `req` = 4'b0100 with `d2` = 2'b10 → `gnt` = 4'b0100 and `sel` = 2 after 1 edge. After the next edge, `q` = 2'b10 and `q_valid` = 1. Drop `req[2]` → `gnt` = 0 for one GAP cycle.
- Priority rotation: hold `req` = 4'b1010 with `ptr` = 1 → grant 3 first. Release it → grant 1 after the GAP cycle.
- Timeout (macro on, `MAX_HOLD` = 4): hold `req` = 4'b1111 → grants 0,1,2,3,0. Each grant lasts 4 BUSY cycles, and each is separated by 1 GAP cycle.
- No timeout (macro off): same stimulus as the timeout scenario → `gnt` = 4'b0001 indefinitely.
- Reset mid-BUSY: reset while `gnt` = 4'b0100, then keep `req` = 4'b0101 → `gnt` = 0 and `q_valid` = 0 immediately. After reset releases, the first grant is 4'b0001.
